// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/DS requesters, the shared memory port and the arbiter.
// master = arbiter side, slave = requester/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ds_req;
  logic        ds_we;
  logic [31:0] ds_addr;
  logic [31:0] ds_wdata;
  logic [2:0]  ds_funct3;
  logic        ds_gnt;
  logic        ds_rvalid;
  logic [31:0] ds_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  logic        busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ds_req, ds_we, ds_addr, ds_wdata, ds_funct3,
    output ds_gnt, ds_rvalid, ds_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we, mem_funct3,
    input  mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ds_req, ds_we, ds_addr, ds_wdata, ds_funct3,
    input  ds_gnt, ds_rvalid, ds_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we, mem_funct3,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the data stage (DS):
// data-first priority with a starvation guard, fixed wait states per access.
//
//   state  | meaning
//   IDLE   | port released, mem_* at 0; arbitrate and grant in the same cycle
//   ACCESS | port driven with the latched request for WAIT_CYCLES cycles
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_MAX   = 4,
  parameter logic [31:0] DS_ADDR_MASK = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [3:0]  starve_cnt, starve_cnt_nxt;
  logic        owner_ds, owner_ds_nxt;

  logic [31:0] mem_addr_q, mem_addr_nxt;
  logic [31:0] mem_wdata_q, mem_wdata_nxt;
  logic        mem_re_q, mem_re_nxt;
  logic        mem_we_q, mem_we_nxt;
  logic [2:0]  mem_funct3_q, mem_funct3_nxt;

  logic        if_rvalid_q, if_rvalid_nxt;
  logic        ds_rvalid_q, ds_rvalid_nxt;
  logic [31:0] if_rdata_q, if_rdata_nxt;
  logic [31:0] ds_rdata_q, ds_rdata_nxt;

  logic        grant_if, grant_ds;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      starve_cnt   <= '0;
      owner_ds     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_funct3_q <= '0;
      if_rvalid_q  <= 1'b0;
      ds_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ds_rdata_q   <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      starve_cnt   <= starve_cnt_nxt;
      owner_ds     <= owner_ds_nxt;
      mem_addr_q   <= mem_addr_nxt;
      mem_wdata_q  <= mem_wdata_nxt;
      mem_re_q     <= mem_re_nxt;
      mem_we_q     <= mem_we_nxt;
      mem_funct3_q <= mem_funct3_nxt;
      if_rvalid_q  <= if_rvalid_nxt;
      ds_rvalid_q  <= ds_rvalid_nxt;
      if_rdata_q   <= if_rdata_nxt;
      ds_rdata_q   <= ds_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    starve_cnt_nxt = starve_cnt;
    owner_ds_nxt   = owner_ds;
    mem_addr_nxt   = mem_addr_q;
    mem_wdata_nxt  = mem_wdata_q;
    mem_re_nxt     = mem_re_q;
    mem_we_nxt     = mem_we_q;
    mem_funct3_nxt = mem_funct3_q;
    if_rvalid_nxt  = 1'b0;
    ds_rvalid_nxt  = 1'b0;
    if_rdata_nxt   = if_rdata_q;
    ds_rdata_nxt   = ds_rdata_q;
    grant_if       = 1'b0;
    grant_ds       = 1'b0;

    if (!bus.if_req) begin
      starve_cnt_nxt = '0;
    end

    case (state)
      IDLE: begin
        // Grants are decoded straight from IDLE so the requester sees gnt in
        // the cycle it asks; gating with reset keeps them low while resetting.
        if (!reset) begin
          if (bus.ds_req && !(bus.if_req && starve_cnt == STARVE_LIM)) begin
            grant_ds = 1'b1;
          end else if (bus.if_req) begin
            grant_if = 1'b1;
          end
        end

        if (grant_ds) begin
          state_nxt      = ACCESS;
          wait_cnt_nxt   = WAIT_INIT;
          owner_ds_nxt   = 1'b1;
          mem_addr_nxt   = bus.ds_addr | DS_ADDR_MASK;
          mem_we_nxt     = bus.ds_we;
          mem_re_nxt     = ~bus.ds_we;
          mem_wdata_nxt  = bus.ds_we ? bus.ds_wdata : '0;
          mem_funct3_nxt = bus.ds_funct3;
          if (bus.if_req) begin
            starve_cnt_nxt = (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
          end
        end else if (grant_if) begin
          state_nxt      = ACCESS;
          wait_cnt_nxt   = WAIT_INIT;
          owner_ds_nxt   = 1'b0;
          mem_addr_nxt   = bus.if_addr;
          mem_we_nxt     = 1'b0;
          mem_re_nxt     = 1'b1;
          mem_wdata_nxt  = '0;
          mem_funct3_nxt = FUNCT3_WORD;
          starve_cnt_nxt = '0;
        end
      end

      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          state_nxt      = IDLE;
          mem_addr_nxt   = '0;
          mem_wdata_nxt  = '0;
          mem_re_nxt     = 1'b0;
          mem_we_nxt     = 1'b0;
          mem_funct3_nxt = '0;
          if (owner_ds) begin
            ds_rvalid_nxt = 1'b1;
            if (!mem_we_q) begin
              ds_rdata_nxt = bus.mem_rdata;
            end
          end else begin
            if_rvalid_nxt = 1'b1;
            if_rdata_nxt  = bus.mem_rdata;
          end
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.if_gnt     = grant_if;
  assign bus.ds_gnt     = grant_ds;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.ds_rvalid  = ds_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.ds_rdata   = ds_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_funct3 = mem_funct3_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut1 has WAIT_CYCLES=1/STARVE_MAX=2,
// dut3 has WAIT_CYCLES=3/STARVE_MAX=4.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst1, rst3;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if b1();
  mem_port_arbiter_if b3();

  mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_MAX(2)) dut1 (.clk(clk), .reset(rst1), .bus(b1.master));
  mem_port_arbiter #(.WAIT_CYCLES(3), .STARVE_MAX(4)) dut3 (.clk(clk), .reset(rst3), .bus(b3.master));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.if_req = 0; b1.if_addr = 0; b1.ds_req = 0; b1.ds_we = 0;
    b1.ds_addr = 0; b1.ds_wdata = 0; b1.ds_funct3 = 0; b1.mem_rdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.ds_req = 0; b3.ds_we = 0;
    b3.ds_addr = 0; b3.ds_wdata = 0; b3.ds_funct3 = 0; b3.mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst1 = 1; rst3 = 1;
    b1.if_req = 1; b1.ds_req = 1; b3.if_req = 1;
    tick(); tick();
    #1;
    n_checks++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", b1.busy); end
    n_checks++; if (b1.if_gnt !== 1'b0 || b1.ds_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got if=%b ds=%b exp 0", b1.if_gnt, b1.ds_gnt); end
    n_checks++; if (b3.if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt3 got %b exp 0", b3.if_gnt); end
    n_checks++; if (b1.mem_re !== 1'b0 || b1.mem_we !== 1'b0 || b1.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem got re=%b we=%b addr=%h exp 0", b1.mem_re, b1.mem_we, b1.mem_addr); end
    n_checks++; if (b1.if_rdata !== 32'h0 || b1.ds_rdata !== 32'h0 || b1.if_rvalid !== 1'b0 || b1.ds_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got if_rdata=%h ds_rdata=%h exp 0", b1.if_rdata, b1.ds_rdata); end
    idle_inputs();
    rst1 = 0; rst3 = 0;
    tick();
  endtask

  task automatic test_single_fetch();
    tick();
    b1.if_req = 1; b1.if_addr = 32'h10; b1.mem_rdata = 32'h0050_0093;
    #1;
    n_checks++; if (b1.if_gnt !== 1'b1 || b1.ds_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt got if=%b ds=%b exp 1/0", b1.if_gnt, b1.ds_gnt); end
    n_checks++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_T got %b exp 0", b1.busy); end
    tick();
    b1.if_req = 0; b1.if_addr = 32'hFFFF_FFF0;
    #1;
    n_checks++; if (b1.mem_re !== 1'b1 || b1.mem_we !== 1'b0 || b1.mem_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_mem got re=%b we=%b addr=%h exp 1 0 00000010", b1.mem_re, b1.mem_we, b1.mem_addr); end
    n_checks++; if (b1.mem_funct3 !== 3'b010 || b1.busy !== 1'b1) begin n_fail++; $display("FAIL fetch_f3_busy got f3=%b busy=%b exp 010 1", b1.mem_funct3, b1.busy); end
    tick();
    b1.mem_rdata = 32'h1111_1111;
    #1;
    n_checks++; if (b1.if_rvalid !== 1'b1 || b1.if_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_rsp got rvalid=%b rdata=%h exp 1 00500093", b1.if_rvalid, b1.if_rdata); end
    n_checks++; if (b1.busy !== 1'b0 || b1.mem_re !== 1'b0 || b1.mem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_release got busy=%b re=%b addr=%h exp 0", b1.busy, b1.mem_re, b1.mem_addr); end
    tick();
    #1;
    n_checks++; if (b1.if_rvalid !== 1'b0 || b1.if_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_hold got rvalid=%b rdata=%h exp 0 00500093", b1.if_rvalid, b1.if_rdata); end
  endtask

  task automatic test_load_w1();
    tick();
    b1.ds_req = 1; b1.ds_we = 0; b1.ds_addr = 32'h8; b1.ds_funct3 = 3'b101; b1.mem_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (b1.ds_gnt !== 1'b1) begin n_fail++; $display("FAIL load1_gnt got %b exp 1", b1.ds_gnt); end
    tick();
    b1.ds_req = 0;
    #1;
    n_checks++; if (b1.mem_addr !== 32'h8000_0008 || b1.mem_re !== 1'b1 || b1.mem_funct3 !== 3'b101 || b1.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL load1_mem got addr=%h re=%b f3=%b wdata=%h", b1.mem_addr, b1.mem_re, b1.mem_funct3, b1.mem_wdata); end
    tick();
    #1;
    n_checks++; if (b1.ds_rvalid !== 1'b1 || b1.ds_rdata !== 32'hCAFE_F00D || b1.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL load1_rsp got rvalid=%b rdata=%h exp 1 cafef00d", b1.ds_rvalid, b1.ds_rdata); end
  endtask

  task automatic test_store();
    tick();
    b1.ds_req = 1; b1.ds_we = 1; b1.ds_addr = 32'h24; b1.ds_wdata = 32'hDEAD_BEEF; b1.ds_funct3 = 3'b000;
    b1.mem_rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (b1.ds_gnt !== 1'b1 || b1.if_gnt !== 1'b0) begin n_fail++; $display("FAIL store_gnt got ds=%b if=%b exp 1 0", b1.ds_gnt, b1.if_gnt); end
    tick();
    b1.ds_req = 0; b1.ds_addr = 32'h0000_0FFC; b1.ds_wdata = 32'h0; b1.ds_we = 0; b1.ds_funct3 = 3'b111;
    #1;
    n_checks++; if (b1.mem_addr !== 32'h8000_0024 || b1.mem_we !== 1'b1 || b1.mem_re !== 1'b0) begin n_fail++; $display("FAIL store_mem got addr=%h we=%b re=%b exp 80000024 1 0", b1.mem_addr, b1.mem_we, b1.mem_re); end
    n_checks++; if (b1.mem_funct3 !== 3'b000 || b1.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_data got f3=%b wdata=%h exp 000 deadbeef", b1.mem_funct3, b1.mem_wdata); end
    tick();
    #1;
    n_checks++; if (b1.ds_rvalid !== 1'b1 || b1.ds_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_rsp got rvalid=%b rdata=%h exp 1 cafef00d", b1.ds_rvalid, b1.ds_rdata); end
    n_checks++; if (b1.mem_we !== 1'b0 || b1.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL store_release got we=%b wdata=%h exp 0", b1.mem_we, b1.mem_wdata); end
  endtask

  task automatic test_simultaneous();
    tick();
    b1.if_req = 1; b1.if_addr = 32'h40; b1.ds_req = 1; b1.ds_we = 0; b1.ds_addr = 32'h4;
    #1;
    n_checks++; if (b1.ds_gnt !== 1'b1 || b1.if_gnt !== 1'b0) begin n_fail++; $display("FAIL simul_T got ds=%b if=%b exp 1 0", b1.ds_gnt, b1.if_gnt); end
    tick();
    b1.ds_req = 0;
    #1;
    n_checks++; if (b1.ds_gnt !== 1'b0 || b1.if_gnt !== 1'b0) begin n_fail++; $display("FAIL simul_T1 got ds=%b if=%b exp 0 0", b1.ds_gnt, b1.if_gnt); end
    tick();
    #1;
    n_checks++; if (b1.if_gnt !== 1'b1 || b1.ds_gnt !== 1'b0 || b1.ds_rvalid !== 1'b1) begin n_fail++; $display("FAIL simul_T2 got if=%b ds=%b ds_rvalid=%b exp 1 0 1", b1.if_gnt, b1.ds_gnt, b1.ds_rvalid); end
    tick();
    b1.if_req = 0;
    #1;
    n_checks++; if (b1.mem_addr !== 32'h40 || b1.mem_re !== 1'b1) begin n_fail++; $display("FAIL simul_if_mem got addr=%h re=%b exp 00000040 1", b1.mem_addr, b1.mem_re); end
    tick(); tick();
  endtask

  task automatic test_starvation();
    logic [5:0] order;   // 1 = DS grant, 0 = IF grant, oldest in bit 0
    int         n_gnt;
    bit         chk_cnt;
    order = '0; n_gnt = 0; chk_cnt = 0;
    tick();
    b1.if_req = 1; b1.if_addr = 32'h80; b1.ds_req = 1; b1.ds_we = 0; b1.ds_addr = 32'hC;
    for (int cyc = 0; cyc < 40 && n_gnt < 6; cyc++) begin
      #1;
      if (chk_cnt) begin
        n_checks++; if (dut1.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL starve_clear got %0d exp 0", dut1.starve_cnt); end
        chk_cnt = 0;
      end
      n_checks++; if (b1.if_gnt === 1'b1 && b1.ds_gnt === 1'b1) begin n_fail++; $display("FAIL starve_dual_gnt got both exp one"); end
      if (b1.ds_gnt === 1'b1) begin order[n_gnt] = 1'b1; n_gnt++; end
      else if (b1.if_gnt === 1'b1) begin order[n_gnt] = 1'b0; n_gnt++; chk_cnt = 1; end
      tick();
    end
    n_checks++; if (n_gnt != 6) begin n_fail++; $display("FAIL starve_timeout got %0d grants exp 6", n_gnt); end
    n_checks++; if (order !== 6'b011011) begin n_fail++; $display("FAIL starve_order got %b exp 011011 (bit0 first, 1=DS)", order); end
    b1.if_req = 0; b1.ds_req = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_wait3_load();
    tick();
    b3.ds_req = 1; b3.ds_we = 0; b3.ds_addr = 32'h40; b3.ds_funct3 = 3'b100; b3.mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (b3.ds_gnt !== 1'b1) begin n_fail++; $display("FAIL w3_gnt got %b exp 1", b3.ds_gnt); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      b3.ds_req = 0;
      b3.mem_rdata = (k == 3) ? 32'h1234_5678 : 32'hFFFF_FFFF;
      #1;
      n_checks++; if (b3.mem_re !== 1'b1 || b3.mem_addr !== 32'h8000_0040 || b3.mem_funct3 !== 3'b100 || b3.ds_rvalid !== 1'b0 || b3.busy !== 1'b1) begin n_fail++; $display("FAIL w3_access%0d got re=%b addr=%h f3=%b rvalid=%b busy=%b", k, b3.mem_re, b3.mem_addr, b3.mem_funct3, b3.ds_rvalid, b3.busy); end
    end
    tick();
    b3.mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (b3.ds_rvalid !== 1'b1 || b3.ds_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL w3_rsp got rvalid=%b rdata=%h exp 1 12345678", b3.ds_rvalid, b3.ds_rdata); end
    n_checks++; if (b3.mem_re !== 1'b0 || b3.busy !== 1'b0) begin n_fail++; $display("FAIL w3_release got re=%b busy=%b exp 0 0", b3.mem_re, b3.busy); end
  endtask

  task automatic test_reset_mid_access();
    bit saw_rvalid;
    saw_rvalid = 0;
    tick();
    b3.if_req = 1; b3.if_addr = 32'h100; b3.mem_rdata = 32'hAAAA_5555;
    #1;
    n_checks++; if (b3.if_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got %b exp 1", b3.if_gnt); end
    tick();
    b3.if_req = 0;
    tick();
    rst3 = 1;
    #1;
    n_checks++; if (b3.busy !== 1'b1 || b3.mem_addr !== 32'h100) begin n_fail++; $display("FAIL rstmid_pre got busy=%b addr=%h exp 1 00000100", b3.busy, b3.mem_addr); end
    tick();
    rst3 = 0;
    #1;
    n_checks++; if (b3.busy !== 1'b0 || b3.mem_re !== 1'b0 || b3.mem_addr !== 32'h0 || b3.mem_funct3 !== 3'b0) begin n_fail++; $display("FAIL rstmid_outs got busy=%b re=%b addr=%h f3=%b exp 0", b3.busy, b3.mem_re, b3.mem_addr, b3.mem_funct3); end
    n_checks++; if (b3.if_rdata !== 32'h0 || b3.ds_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata got if=%h ds=%h exp 0", b3.if_rdata, b3.ds_rdata); end
    for (int k = 0; k < 6; k++) begin
      if (b3.if_rvalid === 1'b1 || b3.busy === 1'b1) saw_rvalid = 1;
      tick();
    end
    n_checks++; if (saw_rvalid) begin n_fail++; $display("FAIL rstmid_no_rvalid got activity after reset exp none"); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_load_w1();
    test_store();
    test_simultaneous();
    test_starvation();
    test_wait3_load();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between the instruction-fetch requester (IF) and the data-stage requester (DS) of the pipelined CPU.
- Replaces the combinational fetch/data address muxing with a registered request/grant/response handshake.
- Supports a configurable number of memory wait states.
- Uses fixed data-first priority, with a starvation guard so instruction fetch always makes progress.

Parameters:
- WAIT_CYCLES, 1, cycles the memory port is driven per access; legal range 1..15.
- STARVE_MAX, 4, consecutive DS grants allowed while IF is pending before IF is forced to win; legal range 1..15.
- DS_ADDR_MASK, 32'h8000_0000, OR'd into every DS address to select data space.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- ds_req  in  1  data request; held with ds_* until ds_gnt
- ds_we  in  1  1 = store, 0 = load
- ds_addr  in  32  data address
- ds_wdata  in  32  store data (already extended)
- ds_funct3  in  3  access size/sign code
- ds_gnt  out  1  one-cycle pulse: data request accepted
- ds_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- ds_rdata  out  32  load data
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_funct3  out  3  access size code to the memory extender
- mem_rdata  in  32  memory read data
- busy  out  1  high whenever state != IDLE; used as a stall source

Behaviour:
- Reset: the following are registered and clear to 0 on reset:
  - FSM to IDLE, starvation counter, wait counter.
  - if_gnt, ds_gnt, if_rvalid, ds_rvalid, if_rdata, ds_rdata.
  - mem_re, mem_we, mem_addr, mem_wdata, mem_funct3.
  - busy is derived from FSM state and is therefore also 0 during reset.
- Reset mid-access: abort immediately; no rvalid is ever produced for the aborted request.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - mem_re, mem_we, mem_addr, mem_wdata and mem_funct3 are all 0.
  - If any request is pending, arbitrate in that cycle (T) and pulse the winner's gnt in cycle T.
  - Latch the winner: owner, address, wdata, we, funct3.
  - Go to ACCESS with wait counter = WAIT_CYCLES-1.
- Arbitration:
  - DS wins if ds_req=1, unless if_req=1 and starve_cnt==STARVE_MAX; in that case IF wins.
  - Only one gnt is asserted in any cycle.
- Starvation counter:
  - Increments on each DS grant made while if_req=1.
  - Clears on an IF grant, or in any cycle where if_req=0.
  - Saturates at STARVE_MAX.
- ACCESS, mem_addr:
  - IF owner: latched if_addr.
  - DS owner: latched ds_addr | DS_ADDR_MASK.
- ACCESS, enables and size:
  - mem_we = latched ds_we (DS owner only).
  - mem_re = ~mem_we.
  - mem_funct3 = 3'b010 for IF; latched ds_funct3 for DS.
  - mem_wdata = latched ds_wdata for DS stores, else 0.
- ACCESS, completion:
  - Wait counter decrements each cycle.
  - In the cycle the counter is 0: sample mem_rdata into the owner's rdata register and return to IDLE.
  - Owner's rvalid pulses in the following cycle: T+WAIT_CYCLES+1.
- Rdata registers:
  - Stores also pulse ds_rvalid; ds_rdata keeps its previous value on a store.
  - rdata registers hold their value until overwritten.
- Back-to-back: the rvalid cycle is an IDLE cycle, so a new grant may occur in the same cycle as rvalid. Throughput is one access per WAIT_CYCLES+1 cycles.
- Handshake boundaries:
  - A request dropped before grant is ignored.
  - Requests arriving while busy wait in their requester; nothing is queued internally.
  - Inputs may change freely after gnt; all access fields are latched at grant.
- Simultaneous if_req and ds_req with starve_cnt < STARVE_MAX: DS wins; IF stays pending.
- Counter width is 4 bits, sized to cover both WAIT_CYCLES and STARVE_MAX maxima; no wrap-around is possible within legal parameter ranges.

Test Plan:
- Single fetch, WAIT_CYCLES=1:
  - Stimulus: if_req with if_addr=0x10; memory returns 0x00500093.
  - Response: if_gnt at T, mem_re=1 and mem_addr=0x10 at T+1, if_rvalid with if_rdata=0x00500093 at T+2, busy high only at T+1.
- Data store:
  - Stimulus: ds_req, ds_we=1, ds_addr=0x24, ds_wdata=0xDEADBEEF, ds_funct3=3'b000.
  - Response: mem_addr=0x80000024, mem_we=1, mem_re=0, mem_funct3=0, mem_wdata=0xDEADBEEF for one cycle; ds_rvalid pulses next cycle; ds_rdata unchanged.
- Simultaneous requests:
  - Stimulus: if_req and ds_req both high at T.
  - Response: ds_gnt at T, if_gnt at T+2 (WAIT_CYCLES=1), never both gnt in one cycle.
- Starvation, STARVE_MAX=2:
  - Stimulus: if_req and ds_req held high continuously.
  - Response: grant order DS, DS, IF, DS, DS, IF; starvation counter clears after each IF grant.
- WAIT_CYCLES=3 load:
  - Stimulus: load with mem_rdata=0x12345678 presented only in the 3rd ACCESS cycle.
  - Response: ds_rdata=0x12345678 and ds_rvalid at T+4; mem_re high for exactly 3 cycles.
- Reset mid-access:
  - Stimulus: assert reset in the 2nd ACCESS cycle of a WAIT_CYCLES=3 fetch.
  - Response: next cycle all outputs 0 and FSM in IDLE; no if_rvalid ever produced.
